// File: rtl/mix_column_sequencer.sv
// Round-datapath sequencer: issues four state columns to an external MixColumns stage,
// adds the round key to each returned column and repacks a 128-bit round result.
module mcs_col_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_cap_vld,
  input  logic [1:0]  i_cap_tag,
  input  logic [31:0] i_col,
  output logic [31:0] o_word
);
  logic [31:0] r_word;

  always_ff @(posedge clock) begin
    if (reset)                                 r_word <= '0;
    else if (i_cap_vld && (i_cap_tag == LANE)) r_word <= i_col;
  end

  assign o_word = r_word;
endmodule

module mix_column_sequencer #(
  parameter int MIX_LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic [31:0]  mix_col_out,
  input  logic [31:0]  mix_col_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [1:0] DRAIN_LAST = 2'(MIX_LATENCY - 1);

  logic [1:0]   r_state;
  logic [1:0]   r_issue_cnt;
  logic [1:0]   r_drain_cnt;
  logic [127:0] r_st;
  logic [127:0] r_key;
  logic         r_last;
  logic [31:0]  r_mix_out;

  logic [MIX_LATENCY-1:0]       r_vld_pipe;
  logic [MIX_LATENCY-1:0][1:0]  r_tag_pipe;
  logic [MIX_LATENCY-1:0][31:0] r_raw_pipe;

  logic         w_accept;
  logic [1:0]   w_next_idx;
  logic [31:0]  w_next_col;
  logic         w_cap_vld;
  logic [1:0]   w_cap_tag;
  logic [31:0]  w_cap_raw;
  logic [31:0]  w_key_word;
  logic [31:0]  w_cap_col;
  logic [3:0][31:0] w_res;

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign mix_col_out = r_mix_out;

  assign w_next_idx = r_issue_cnt + 2'd1;

  always_comb begin
    w_next_col = r_st[127:96];
    case (w_next_idx)
      2'd0: w_next_col = r_st[127:96];
      2'd1: w_next_col = r_st[95:64];
      2'd2: w_next_col = r_st[63:32];
      2'd3: w_next_col = r_st[31:0];
      default: w_next_col = r_st[127:96];
    endcase
  end

  // Column 0 is loaded on the accept edge so it is on the bus in the first ISSUE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_drain_cnt <= '0;
      r_st        <= '0;
      r_key       <= '0;
      r_last      <= 1'b0;
      r_mix_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_st        <= in_state;
            r_key       <= in_key;
            r_last      <= in_last;
            r_issue_cnt <= '0;
            r_mix_out   <= in_state[127:96];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_issue_cnt <= w_next_idx;
          if (r_issue_cnt == 2'd3) begin
            r_drain_cnt <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_mix_out <= w_next_col;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) r_state <= S_DONE;
          else                           r_drain_cnt <= r_drain_cnt + 2'd1;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Raw column + tag travel alongside MixColumns so the bypass path lines up with mix_col_in.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
      r_raw_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= (r_state == S_ISSUE);
      r_tag_pipe[0] <= r_issue_cnt;
      r_raw_pipe[0] <= r_mix_out;
      for (int i = 1; i < MIX_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
        r_raw_pipe[i] <= r_raw_pipe[i-1];
      end
    end
  end

  assign w_cap_vld = r_vld_pipe[MIX_LATENCY-1];
  assign w_cap_tag = r_tag_pipe[MIX_LATENCY-1];
  assign w_cap_raw = r_raw_pipe[MIX_LATENCY-1];

  always_comb begin
    w_key_word = r_key[127:96];
    case (w_cap_tag)
      2'd0: w_key_word = r_key[127:96];
      2'd1: w_key_word = r_key[95:64];
      2'd2: w_key_word = r_key[63:32];
      2'd3: w_key_word = r_key[31:0];
      default: w_key_word = r_key[127:96];
    endcase
  end

  assign w_cap_col = (r_last ? w_cap_raw : mix_col_in) ^ w_key_word;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      mcs_col_lane #(.LANE(2'(g))) u_lane (
        .clock     (clock),
        .reset     (reset),
        .i_cap_vld (w_cap_vld),
        .i_cap_tag (w_cap_tag),
        .i_col     (w_cap_col),
        .o_word    (w_res[g])
      );
    end
  endgenerate

  assign out_state = {w_res[0], w_res[1], w_res[2], w_res[3]};
endmodule

// File: tb/tb_mix_column_sequencer.sv
// Directed bench for mix_column_sequencer with a registered MixColumns stand-in.
module tb_mix_column_sequencer;
  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic [31:0]  mix_col_out;
  logic [31:0]  mix_col_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] ST_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] EXP_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KEY_B = 128'hffffffff_00000000_ffffffff_00000000;
  localparam logic [127:0] EXP_B = 128'h71b25e43_9fdc589d_fefefefe_c6c6c6c6;
  localparam logic [127:0] ST_C  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_C = {128{1'b1}};
  localparam logic [127:0] EXP_C = 128'hffeeddcc_bbaa9988_77665544_33221100;

  mix_column_sequencer #(.MIX_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_last(in_last),
    .mix_col_out(mix_col_out), .mix_col_in(mix_col_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // One-cycle MixColumns stage in front of the DUT
  always @(posedge clock) mix_col_in <= mixcol(mix_col_out);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Offer a state, wait for accept, then count edges until out_valid.
  task automatic run_one(input logic [127:0] s, input logic [127:0] k, input logic l,
                         input logic [127:0] exp, input string tag);
    int n;
    in_state = s; in_key = k; in_last = l; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    chk({tag, "_ready"}, 128'(in_ready), 128'd1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    chk({tag, "_lat"}, 128'(n), 128'd5);
    chk({tag, "_state"}, out_state, exp);
  endtask

  logic [127:0] b2b_st  [3];
  logic [127:0] b2b_key [3];
  logic         b2b_last[3];
  logic [127:0] b2b_exp [3];

  initial begin
    int idx, nout, cyc, extra;
    int out_t[3];
    logic acc;

    reset = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0; in_last = 1'b0;
    out_ready = 1'b0;
    tick; tick;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_mix_out", 128'(mix_col_out), 128'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);

    // plain MixColumns, key 0
    run_one(ST_A, '0, 1'b0, EXP_A, "mixA");
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("mixA_ovld_drop", 128'(out_valid), 128'd0);
    chk("mixA_in_ready", 128'(in_ready), 128'd1);

    // reset two cycles into a transaction
    in_state = ST_C; in_key = KEY_B; in_last = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    chk("mrst_out_valid", 128'(out_valid), 128'd0);
    chk("mrst_out_state", out_state, 128'd0);
    chk("mrst_in_ready", 128'(in_ready), 128'd0);
    reset = 1'b0;
    #1;
    chk("mrst_rel_ready", 128'(in_ready), 128'd1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin tick; if (out_valid) extra++; end
    chk("mrst_no_pulse", 128'(extra), 128'd0);

    // key add after reset
    run_one(ST_A, KEY_B, 1'b0, EXP_B, "keyB");
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // final round with backpressure; in_valid offered in DONE must be ignored
    run_one(ST_C, KEY_C, 1'b1, EXP_C, "lastC");
    in_state = ST_A; in_key = KEY_B; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_state", out_state, EXP_C);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_xfer_ovld", 128'(out_valid), 128'd0);
    chk("bp_xfer_ready", 128'(in_ready), 128'd1);
    tick;
    chk("bp_no_dup", 128'(out_valid), 128'd0);

    // back-to-back with both handshakes held high
    b2b_st[0] = ST_A; b2b_key[0] = '0;    b2b_last[0] = 1'b0; b2b_exp[0] = EXP_A;
    b2b_st[1] = ST_A; b2b_key[1] = KEY_B; b2b_last[1] = 1'b0; b2b_exp[1] = EXP_B;
    b2b_st[2] = ST_C; b2b_key[2] = KEY_C; b2b_last[2] = 1'b1; b2b_exp[2] = EXP_C;
    idx = 0; nout = 0; cyc = 0;
    in_state = b2b_st[0]; in_key = b2b_key[0]; in_last = b2b_last[0]; in_valid = 1'b1;
    out_ready = 1'b1;
    while (nout < 3 && cyc < 100) begin
      if (out_valid) begin
        chk("b2b_state", out_state, b2b_exp[nout]);
        out_t[nout] = cyc;
        nout++;
      end
      acc = in_valid && in_ready;
      tick;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_state = b2b_st[idx]; in_key = b2b_key[idx]; in_last = b2b_last[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 128'(nout), 128'd3);
    if (nout == 3) begin
      chk("b2b_gap1", 128'(out_t[1] - out_t[0]), 128'd7);
      chk("b2b_gap2", 128'(out_t[2] - out_t[1]), 128'd7);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) extra++;
      tick;
    end
    chk("b2b_no_extra", 128'(extra), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mix_column_sequencer.md
Name: mix_column_sequencer

Overview:
- Round-datapath sequencer wrapped around the one-cycle MixColumes stage.
- Accepts a full 128-bit AES state plus a 128-bit round key.
- Serialises the state into four 32-bit columns, drives them into MixColumes, and collects the returned columns.
- XORs each returned column with the matching round-key word (AddRoundKey) and repacks a 128-bit result with valid/ready handshake.
- Sits between the SubBytes/ShiftRows stage (upstream) and the round-state register / key-schedule consumer (downstream).

Parameters:
- MIX_LATENCY, 1, cycles from driving mix_col_out to the corresponding mix_col_in being valid. Legal range 1..3. Must be 1 with MixColumes.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream offers in_state/in_key/in_last
- in_ready  output  1  block can accept; high only in IDLE
- in_state  input  128  AES state, column c in [127-32c -: 32], byte row 0 in column MSB
- in_key  input  128  round key, same column layout
- in_last  input  1  final round: bypass MixColumns, XOR key onto raw column
- mix_col_out  output  32  column to MixColumes in_columes, {row0,row1,row2,row3}
- mix_col_in  input  32  MixColumes out_result
- out_valid  output  1  out_state valid
- out_ready  input  1  downstream accepts
- out_state  output  128  round result, same layout as in_state

Behaviour:
- Reset values: in_ready=0 during reset, 1 in the first cycle after reset release. out_valid=0, out_state=0, mix_col_out=0, FSM=IDLE, counters=0. All in-flight data discarded.
- Reset is honoured in any state, including mid-ISSUE or DONE. No partial out_valid pulse follows.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0:
  - latch in_state, in_key, in_last;
  - issue counter := 0;
  - go to ISSUE.
- ISSUE: mix_col_out = latched column[issue_cnt]. issue_cnt increments every cycle. The cycle with issue_cnt=3 transitions to DRAIN.
- Raw-column delay line: MIX_LATENCY stages, in parallel with MixColumes. Each entry carries the raw column, a 2-bit column tag and a valid bit, so the bypass column arrives aligned with mix_col_in.
- Capture: when the delayed tag valid is set, result column[tag] := (in_last ? delayed_raw : mix_col_in) ^ key word[tag].
- DRAIN: waits until the tag pipeline is empty (MIX_LATENCY cycles), then goes to DONE and sets out_valid.
- Timing at MIX_LATENCY=1:
  - column c is driven in the cycle after edge E(c);
  - column c is captured at edge E(c+2);
  - out_valid is high from edge E5.
  - Accept-to-out_valid latency = 4+MIX_LATENCY edges.
- DONE:
  - out_valid=1; out_state stable while out_ready=0;
  - on out_valid&out_ready go to IDLE, out_valid=0 next cycle;
  - in_ready rises in the same edge (no same-cycle accept/deliver bypass).
- Throughput: one state per 6+MIX_LATENCY cycles under continuous handshakes.
- mix_col_out holds its last driven column outside ISSUE. The value is don't-care; only the tag-valid capture path matters.
- in_valid while in_ready=0 is ignored. Upstream holds data until accepted.
- All XOR arithmetic is bitwise GF(2), width 32 per column. No carries.

Test Plan:
- Reset mid-ISSUE: assert reset two cycles after accept → next cycle out_valid=0, out_state=0; in_ready=1 after release. A new accept then completes normally.
- MixColumns vectors, key=0, in_last=0:
  - in_state=db135345_f20a225c_01010101_c6c6c6c6
  - → out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6
  - out_valid exactly 5 edges after the accept edge.
- Key add: same state, in_key=ffffffff_00000000_ffffffff_00000000 → out_state=71b25e43_9fdc589d_fefefefe_c6c6c6c6.
- Final round: in_last=1, in_state=00112233_44556677_8899aabb_ccddeeff, in_key=all ff → out_state=ffeeddcc_bbaa9988_77665544_33221100 (MixColumns bypassed).
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and out_state stable, in_ready=0, in_valid ignored. Raise out_ready → one transfer, in_ready=1 next cycle.
- Back-to-back: in_valid=1 and out_ready=1 continuously for 3 states → 3 correct results, spacing 7 cycles, no dropped or duplicated outputs.
